apb_slave_regbank: RTL and testbench



---
 rtl/apb_slave_regbank.sv | 146 ++++++++++++++
 tb/tb_apb_slave_regbank.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_regbank.sv
// APB3 completer register bank: NREG word registers with programmable wait
// states (held off via pready) and pslverr for unmapped or misaligned addresses.
module apb_slave_regbank #(
  parameter int              AW     = 8,
  parameter int              DW     = 32,
  parameter int              NREG   = 8,
  parameter logic [DW-1:0]   RST_VL = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 psel,
  input  logic                 penable,
  input  logic                 pwrite,
  input  logic [AW-1:0]        paddr,
  input  logic [DW-1:0]        pwdata,
  input  logic [3:0]           wait_cfg,
  output logic [DW-1:0]        prdata,
  output logic                 pready,
  output logic                 pslverr,
  output logic [NREG*DW-1:0]   reg_out
);

  localparam int IW = AW - 2;

  typedef enum logic {
    S_IDLE,
    S_ACCESS
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            write_q, write_d;
  logic [DW-1:0]   wdata_q, wdata_d;

  logic [IW-1:0]   idx;
  logic            addr_ok;
  logic            complete;
  logic [DW-1:0]   rd_word;

  // Decode works only on the latched request so mid-access bus changes are ignored.
  assign idx      = addr_q[AW-1:2];
  assign addr_ok  = (addr_q[1:0] == 2'b00) && (32'(idx) < 32'(NREG));

  // pready comes purely from registered state, never from the APB inputs.
  assign pready   = (state_q == S_ACCESS) && (cnt_q == 4'd0);
  assign pslverr  = pready && !addr_ok;
  assign complete = psel && penable && pready;

  // Next-state logic: setup latches the request, access counts down wait states.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (psel && !penable) begin
          state_d = S_ACCESS;
          addr_d  = paddr;
          write_d = pwrite;
          wdata_d = pwdata;
          cnt_d   = wait_cfg;
        end
      end
      S_ACCESS: begin
        if (!psel) begin
          // Master abandoned the transfer: drop it without side effects.
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else if (penable) begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Control and latched-request flops, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      logic [DW-1:0] reg_q, reg_d;
      logic          wr_en;

      assign wr_en = complete && write_q && addr_ok && (idx == IW'(gi));

      // Register only changes on the completing edge of a valid write.
      always_comb begin
        reg_d = reg_q;
        if (wr_en) begin
          reg_d = wdata_q;
        end
      end

      // Storage flop for register gi.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          reg_q <= RST_VL;
        end else begin
          reg_q <= reg_d;
        end
      end

      assign reg_out[gi*DW +: DW] = reg_q;
    end
  endgenerate

  // Read mux over the flattened register image.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NREG; i++) begin
      if (idx == IW'(i)) begin
        rd_word = reg_out[i*DW +: DW];
      end
    end
  end

  // Read data is only driven in the completing cycle of a valid read, else zero.
  assign prdata = (pready && !write_q && addr_ok) ? rd_word : '0;

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Directed bench for apb_slave_regbank: reset, zero-wait, wait states,
// errors, abort, mid-transfer reset and back-to-back traffic.
module tb_apb_slave_regbank;

  localparam int AW   = 8;
  localparam int DW   = 32;
  localparam int NREG = 8;

  logic              clk;
  logic              rst_n;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [AW-1:0]     paddr;
  logic [DW-1:0]     pwdata;
  logic [3:0]        wait_cfg;
  logic [DW-1:0]     prdata;
  logic              pready;
  logic              pslverr;
  logic [NREG*DW-1:0] reg_out;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] model [NREG];

  apb_slave_regbank #(
    .AW(AW), .DW(DW), .NREG(NREG), .RST_VL('0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .wait_cfg(wait_cfg),
    .prdata(prdata), .pready(pready), .pslverr(pslverr), .reg_out(reg_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NREG*DW-1:0] model_flat();
    logic [NREG*DW-1:0] v;
    for (int i = 0; i < NREG; i++) v[i*DW +: DW] = model[i];
    return v;
  endfunction

  // One APB transfer. Entered and left at posedge+1 with the bus free,
  // so consecutive calls produce back-to-back transfers.
  task automatic apb_xfer(input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input logic [3:0] w,
                          output logic [DW-1:0] rd, output logic err,
                          output int cycles);
    logic [NREG*DW-1:0] snap;
    logic done;
    snap   = reg_out;
    psel   = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd; wait_cfg = w;
    @(posedge clk); #1;
    penable = 1'b1;
    // Scramble bus inputs mid-access; latched values must be used.
    paddr = ~a; pwdata = ~wd; wait_cfg = ~w;
    cycles = 0; done = 1'b0; rd = '0; err = 1'b0;
    while (!done && cycles < 40) begin
      cycles++;
      @(negedge clk);
      total++;
      if (reg_out !== snap) begin
        bad++;
        $display("FAIL early_update a=%h cyc=%0d reg_out=%h expected=%h", a, cycles, reg_out, snap);
      end
      if (pready) begin
        done = 1'b1; rd = prdata; err = pslverr;
      end else begin
        total++;
        if (pslverr !== 1'b0 || prdata !== '0) begin
          bad++;
          $display("FAIL wait_outputs a=%h pslverr=%b prdata=%h expected 0/0", a, pslverr, prdata);
        end
        @(posedge clk); #1;
      end
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL timeout a=%h pready never rose in 40 cycles", a);
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if (pready !== 1'b0 || pslverr !== 1'b0 || prdata !== '0 || reg_out !== '0) begin
      bad++;
      $display("FAIL reset_outputs pready=%b pslverr=%b prdata=%h reg_out=%h expected all 0",
               pready, pslverr, prdata, reg_out);
    end
    for (int i = 0; i < NREG; i++) begin
      logic [DW-1:0] rd; logic err; int cyc;
      apb_xfer(1'b0, AW'(i*4), '0, 4'd0, rd, err, cyc);
      total++;
      if (rd !== '0 || err !== 1'b0 || cyc !== 1) begin
        bad++;
        $display("FAIL reset_read idx=%0d prdata=%h err=%b cyc=%0d expected 0/0/1", i, rd, err, cyc);
      end
    end
  endtask

  task automatic test_zero_wait();
    logic [DW-1:0] rd; logic err; int cyc;
    apb_xfer(1'b1, 8'h04, 32'hA5A5_0001, 4'd0, rd, err, cyc);
    model[1] = 32'hA5A5_0001;
    total++;
    if (cyc !== 1 || err !== 1'b0 || reg_out[63:32] !== 32'hA5A5_0001) begin
      bad++;
      $display("FAIL zw_write cyc=%0d err=%b reg1=%h expected 1/0/a5a50001", cyc, err, reg_out[63:32]);
    end
    apb_xfer(1'b0, 8'h04, '0, 4'd0, rd, err, cyc);
    total++;
    if (cyc !== 1 || err !== 1'b0 || rd !== 32'hA5A5_0001) begin
      bad++;
      $display("FAIL zw_read cyc=%0d err=%b prdata=%h expected 1/0/a5a50001", cyc, err, rd);
    end
  endtask

  task automatic test_wait_states();
    logic [DW-1:0] rd; logic err; int cyc;
    apb_xfer(1'b1, 8'h08, 32'h1234_5678, 4'd3, rd, err, cyc);
    model[2] = 32'h1234_5678;
    total++;
    if (cyc !== 4 || err !== 1'b0 || reg_out !== model_flat()) begin
      bad++;
      $display("FAIL ws_write cyc=%0d err=%b reg_out=%h expected 4/0/%h", cyc, err, reg_out, model_flat());
    end
    apb_xfer(1'b0, 8'h08, '0, 4'd3, rd, err, cyc);
    total++;
    if (cyc !== 4 || rd !== 32'h1234_5678) begin
      bad++;
      $display("FAIL ws_read cyc=%0d prdata=%h expected 4/12345678", cyc, rd);
    end
  endtask

  task automatic test_errors();
    logic [DW-1:0] rd; logic err; int cyc;
    apb_xfer(1'b1, 8'h20, 32'hFFFF_FFFF, 4'd0, rd, err, cyc);
    total++;
    if (err !== 1'b1 || cyc !== 1 || reg_out !== model_flat()) begin
      bad++;
      $display("FAIL err_wr_range err=%b cyc=%0d reg_out=%h expected 1/1/%h", err, cyc, reg_out, model_flat());
    end
    apb_xfer(1'b1, 8'h05, 32'hFFFF_FFFF, 4'd2, rd, err, cyc);
    total++;
    if (err !== 1'b1 || cyc !== 3 || reg_out !== model_flat()) begin
      bad++;
      $display("FAIL err_wr_misalign err=%b cyc=%0d reg_out=%h expected 1/3/%h", err, cyc, reg_out, model_flat());
    end
    apb_xfer(1'b0, 8'h20, '0, 4'd0, rd, err, cyc);
    total++;
    if (err !== 1'b1 || rd !== '0) begin
      bad++;
      $display("FAIL err_rd err=%b prdata=%h expected 1/0", err, rd);
    end
    apb_xfer(1'b0, 8'h04, '0, 4'd0, rd, err, cyc);
    total++;
    if (err !== 1'b0 || rd !== 32'hA5A5_0001) begin
      bad++;
      $display("FAIL err_recover err=%b prdata=%h expected 0/a5a50001", err, rd);
    end
  endtask

  task automatic test_abort();
    logic [DW-1:0] rd; logic err; int cyc;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 32'hDEAD_BEEF; wait_cfg = 4'd5;
    @(posedge clk); #1;
    penable = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      total++;
      if (pready !== 1'b0) begin
        bad++;
        $display("FAIL abort_wait k=%0d pready=%b expected 0", k, pready);
      end
      @(posedge clk); #1;
    end
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    total++;
    if (pready !== 1'b0 || pslverr !== 1'b0) begin
      bad++;
      $display("FAIL abort_outputs pready=%b pslverr=%b expected 0/0", pready, pslverr);
    end
    @(posedge clk); #1;
    total++;
    if (reg_out !== model_flat() || pready !== 1'b0) begin
      bad++;
      $display("FAIL abort_nowrite reg_out=%h pready=%b expected %h/0", reg_out, pready, model_flat());
    end
    apb_xfer(1'b1, 8'h00, 32'h0BAD_F00D, 4'd0, rd, err, cyc);
    model[0] = 32'h0BAD_F00D;
    apb_xfer(1'b0, 8'h00, '0, 4'd0, rd, err, cyc);
    total++;
    if (rd !== 32'h0BAD_F00D || cyc !== 1 || err !== 1'b0) begin
      bad++;
      $display("FAIL abort_next prdata=%h cyc=%0d err=%b expected 0badf00d/1/0", rd, cyc, err);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] rd; logic err; int cyc;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 32'h5555_AAAA; wait_cfg = 4'd5;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0;
    for (int i = 0; i < NREG; i++) model[i] = '0;
    #1;
    total++;
    if (pready !== 1'b0 || pslverr !== 1'b0 || prdata !== '0 || reg_out !== '0) begin
      bad++;
      $display("FAIL rst_mid pready=%b pslverr=%b prdata=%h reg_out=%h expected all 0",
               pready, pslverr, prdata, reg_out);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    apb_xfer(1'b0, 8'h00, '0, 4'd0, rd, err, cyc);
    total++;
    if (rd !== '0 || cyc !== 1) begin
      bad++;
      $display("FAIL rst_mid_read prdata=%h cyc=%0d expected 0/1", rd, cyc);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] rd; logic err; int cyc;
    for (int i = 0; i < NREG; i++) begin
      logic [3:0] w;
      logic [DW-1:0] v;
      w = 4'($urandom_range(15, 0));
      v = $urandom();
      apb_xfer(1'b1, AW'(i*4), v, w, rd, err, cyc);
      model[i] = v;
      total++;
      if (cyc !== int'(w) + 1 || err !== 1'b0 || reg_out !== model_flat()) begin
        bad++;
        $display("FAIL b2b_write idx=%0d cyc=%0d err=%b reg_out=%h expected %0d/0/%h",
                 i, cyc, err, reg_out, int'(w) + 1, model_flat());
      end
      w = 4'($urandom_range(15, 0));
      apb_xfer(1'b0, AW'(i*4), '0, w, rd, err, cyc);
      total++;
      if (cyc !== int'(w) + 1 || rd !== model[i]) begin
        bad++;
        $display("FAIL b2b_read idx=%0d cyc=%0d prdata=%h expected %0d/%h", i, cyc, rd, int'(w) + 1, model[i]);
      end
    end
    total++;
    if (reg_out !== model_flat()) begin
      bad++;
      $display("FAIL b2b_final reg_out=%h expected %h", reg_out, model_flat());
    end
  endtask

  initial begin
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; wait_cfg = '0;
    for (int i = 0; i < NREG; i++) model[i] = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_errors();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
